// File: rtl/rx_link_pkg.sv
// Shared state encodings and parameter defaults for the receive link controller.
package rx_link_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StHunt    = 3'd1;
    localparam state_t StConfirm = 3'd2;
    localparam state_t StLocked  = 3'd3;

    localparam int unsigned DefCommaLock   = 3;
    localparam int unsigned DefErrMax      = 4;
    localparam int unsigned DefGoodDec     = 16;
    localparam int unsigned DefSlipTimeout = 10;

    // Width-select code that is not a legal expander width.
    localparam logic [1:0] WidthRsvd = 2'b11;

endpackage

// File: rtl/rx_err_monitor.sv
// Error/good-symbol bookkeeping while locked; flags loss of lock when errors pile up.
module rx_err_monitor
    import rx_link_pkg::*;
#(
    parameter int unsigned ERR_MAX  = DefErrMax,
    parameter int unsigned GOOD_DEC = DefGoodDec
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       symStb,
    input  logic       invalido,
    input  logic       clr,
    output logic [2:0] errCnt,
    output logic       lost
);

    localparam int unsigned GoodW = $clog2(GOOD_DEC + 1);

    logic [2:0]       err_q, err_d;
    logic [GoodW-1:0] good_q, good_d;

    always_comb begin
        err_d  = err_q;
        good_d = good_q;
        lost   = 1'b0;
        if (clr) begin
            err_d  = '0;
            good_d = '0;
        end else if (symStb) begin
            if (invalido) begin
                good_d = '0;
                // The error that reaches the limit drops lock; counters restart for the next lock.
                if (err_q >= 3'(ERR_MAX - 1)) begin
                    lost  = 1'b1;
                    err_d = '0;
                end else begin
                    err_d = err_q + 3'd1;
                end
            end else if (good_q >= GoodW'(GOOD_DEC - 1)) begin
                good_d = '0;
                if (err_q != '0) begin
                    err_d = err_q - 3'd1;
                end
            end else begin
                good_d = good_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q  <= '0;
            good_q <= '0;
        end else begin
            err_q  <= err_d;
            good_q <= good_d;
        end
    end

    assign errCnt = err_q;

endmodule

// File: rtl/rx_link_ctrl.sv
// Comma-alignment FSM with bit-slip timer and width-select register for the receive link.
module rx_link_ctrl
    import rx_link_pkg::*;
#(
    parameter int unsigned COMMA_LOCK   = DefCommaLock,
    parameter int unsigned ERR_MAX      = DefErrMax,
    parameter int unsigned GOOD_DEC     = DefGoodDec,
    parameter int unsigned SLIP_TIMEOUT = DefSlipTimeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       symStb,
    input  logic       esK285,
    input  logic       invalido,
    input  logic [1:0] dataSIn,
    output logic       bitSlip,
    output logic       rxValid,
    output logic       syncLost,
    output logic [1:0] dataS,
    output logic [2:0] state,
    output logic [2:0] errCnt
);

    localparam int unsigned SlipW  = $clog2(SLIP_TIMEOUT + 1);
    localparam int unsigned CommaW = $clog2(COMMA_LOCK + 1);

    state_t            state_q, state_d;
    logic [SlipW-1:0]  slip_q, slip_d;
    logic [CommaW-1:0] comma_q, comma_d;
    logic              bit_slip_q, bit_slip_d;
    logic              sync_lost_q, sync_lost_d;
    logic              rx_valid_q;
    logic [1:0]        data_s_q, data_s_d;
    logic              locked, comma_ok, mon_lost;

    assign locked   = (state_q == StLocked);
    assign comma_ok = esK285 && !invalido;

    rx_err_monitor #(
        .ERR_MAX  (ERR_MAX),
        .GOOD_DEC (GOOD_DEC)
    ) u_err_monitor (
        .clk      (clk),
        .rst      (rst),
        .symStb   (symStb && locked),
        .invalido (invalido),
        .clr      (!enb || !locked),
        .errCnt   (errCnt),
        .lost     (mon_lost)
    );

    always_comb begin
        state_d    = state_q;
        slip_d     = slip_q;
        comma_d    = comma_q;
        bit_slip_d = 1'b0;
        if (!enb) begin
            state_d = StIdle;
            slip_d  = '0;
            comma_d = '0;
        end else begin
            case (state_q)
                StIdle: state_d = StHunt;
                StHunt: begin
                    if (symStb) begin
                        if (comma_ok) begin
                            state_d = StConfirm;
                            comma_d = CommaW'(1);
                            slip_d  = '0;
                        end else if (slip_q >= SlipW'(SLIP_TIMEOUT - 1)) begin
                            slip_d     = '0;
                            bit_slip_d = 1'b1;
                        end else begin
                            slip_d = slip_q + 1'b1;
                        end
                    end
                end
                StConfirm: begin
                    if (symStb) begin
                        if (invalido) begin
                            state_d = StHunt;
                            comma_d = '0;
                        end else if (esK285) begin
                            if (comma_q >= CommaW'(COMMA_LOCK - 1)) begin
                                state_d = StLocked;
                                comma_d = '0;
                            end else begin
                                comma_d = comma_q + 1'b1;
                            end
                        end
                    end
                end
                StLocked: begin
                    if (mon_lost) begin
                        state_d = StHunt;
                    end
                end
                default: begin
                    state_d = StIdle;
                    slip_d  = '0;
                    comma_d = '0;
                end
            endcase
        end
    end

    assign sync_lost_d = enb && locked && mon_lost;
    // Width is frozen while locked so the expander never changes mid-stream.
    assign data_s_d = (locked || dataSIn == WidthRsvd) ? data_s_q : dataSIn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            slip_q      <= '0;
            comma_q     <= '0;
            bit_slip_q  <= 1'b0;
            sync_lost_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            data_s_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            slip_q      <= slip_d;
            comma_q     <= comma_d;
            bit_slip_q  <= bit_slip_d;
            sync_lost_q <= sync_lost_d;
            rx_valid_q  <= locked;
            data_s_q    <= data_s_d;
        end
    end

    assign bitSlip  = bit_slip_q;
    assign syncLost = sync_lost_q;
    assign rxValid  = rx_valid_q;
    assign dataS    = data_s_q;
    assign state    = state_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Bench for rx_link_ctrl: directed scenarios with literal expectations plus random traffic vs a model.
module tb_rx_link_ctrl;

    localparam int CommaLock = 3;
    localparam int ErrMax    = 4;
    localparam int GoodDec   = 16;
    localparam int SlipTmo   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       symStb;
    logic       esK285;
    logic       invalido;
    logic [1:0] dataSIn;
    logic       bitSlip;
    logic       rxValid;
    logic       syncLost;
    logic [1:0] dataS;
    logic [2:0] state;
    logic [2:0] errCnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: link phase and counters as plain integers.
    int m_phase = 0;
    int m_slip  = 0;
    int m_comma = 0;
    int m_err   = 0;
    int m_good  = 0;
    int m_bslip = 0;
    int m_lost  = 0;
    int m_valid = 0;
    int m_datas = 0;

    rx_link_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .symStb   (symStb),
        .esK285   (esK285),
        .invalido (invalido),
        .dataSIn  (dataSIn),
        .bitSlip  (bitSlip),
        .rxValid  (rxValid),
        .syncLost (syncLost),
        .dataS    (dataS),
        .state    (state),
        .errCnt   (errCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst) begin
        int ph, sl, cm, er, gd, bs, lo, was_locked;
        if (!rst) begin
            m_phase <= 0; m_slip <= 0; m_comma <= 0; m_err <= 0; m_good <= 0;
            m_bslip <= 0; m_lost <= 0; m_valid <= 0; m_datas <= 0;
        end else begin
            ph = m_phase; sl = m_slip; cm = m_comma; er = m_err; gd = m_good;
            bs = 0; lo = 0;
            was_locked = (m_phase == 3) ? 1 : 0;
            if (!enb) begin
                ph = 0; sl = 0; cm = 0; er = 0; gd = 0;
            end else if (ph == 0) begin
                ph = 1;
            end else if (ph == 1) begin
                if (symStb) begin
                    if (esK285 && !invalido) begin
                        ph = 2; cm = 1; sl = 0;
                    end else begin
                        sl++;
                        if (sl == SlipTmo) begin bs = 1; sl = 0; end
                    end
                end
            end else if (ph == 2) begin
                if (symStb) begin
                    if (invalido) begin
                        ph = 1; cm = 0;
                    end else if (esK285) begin
                        cm++;
                        if (cm == CommaLock) begin ph = 3; cm = 0; er = 0; gd = 0; end
                    end
                end
            end else begin
                if (symStb) begin
                    if (invalido) begin
                        er++; gd = 0;
                    end else begin
                        gd++;
                        if (gd == GoodDec) begin
                            if (er > 0) er--;
                            gd = 0;
                        end
                    end
                    if (er == ErrMax) begin lo = 1; er = 0; gd = 0; ph = 1; end
                end
            end
            if (!was_locked && dataSIn != 2'b11) m_datas <= int'(dataSIn);
            m_phase <= ph; m_slip <= sl; m_comma <= cm; m_err <= er; m_good <= gd;
            m_bslip <= bs; m_lost <= lo; m_valid <= was_locked;
        end
    end

    always @(negedge clk) begin
        check("state", int'(state), m_phase);
        check("errCnt", int'(errCnt), m_err);
        check("bitSlip", int'(bitSlip), m_bslip);
        check("syncLost", int'(syncLost), m_lost);
        check("rxValid", int'(rxValid), m_valid);
        check("dataS", int'(dataS), m_datas);
    end

    task automatic step(input logic s, input logic k, input logic i);
        symStb = s; esK285 = k; invalido = i;
        @(negedge clk);
        #1;
    endtask

    task automatic do_lock();
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        step(0, 0, 0);
    endtask

    initial begin
        int slips;
        int inv_pct, k_pct;
        rst = 1'b0; enb = 1'b0; symStb = 1'b0; esK285 = 1'b0; invalido = 1'b0; dataSIn = 2'b00;
        @(negedge clk); #1;
        check("reset_state", int'(state), 0);
        check("reset_rxValid", int'(rxValid), 0);
        check("reset_dataS", int'(dataS), 0);

        rst = 1'b1;
        step(0, 0, 0); step(0, 0, 0);
        check("idle_hold", int'(state), 0);
        enb = 1'b1;
        step(0, 0, 0);
        check("hunt_entry", int'(state), 1);

        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        check("locked_after_3", int'(state), 3);
        check("rxValid_lag", int'(rxValid), 0);
        step(0, 0, 0);
        check("rxValid_on", int'(rxValid), 1);

        dataSIn = 2'b10;
        step(0, 0, 0);
        check("width_frozen", int'(dataS), 0);
        repeat (4) step(1, 0, 1);
        check("lost_pulse", int'(syncLost), 1);
        check("lost_to_hunt", int'(state), 1);
        step(0, 0, 0);
        check("lost_pulse_end", int'(syncLost), 0);
        check("lost_rxValid", int'(rxValid), 0);
        check("width_after_loss", int'(dataS), 2);
        dataSIn = 2'b11;
        step(0, 0, 0);
        check("width_11_ignored", int'(dataS), 2);
        dataSIn = 2'b00;

        do_lock();
        step(1, 0, 1); step(1, 0, 1);
        repeat (15) step(1, 0, 0);
        step(1, 0, 1); step(1, 0, 1);
        check("good15_lost", int'(state), 1);

        do_lock();
        step(1, 0, 1); step(1, 0, 1);
        repeat (16) step(1, 0, 0);
        step(1, 0, 1); step(1, 0, 1);
        check("good16_held", int'(state), 3);
        check("good16_errCnt", int'(errCnt), 3);

        enb = 1'b0;
        step(0, 0, 0);
        check("enb_off_idle", int'(state), 0);
        enb = 1'b1;
        step(0, 0, 0);
        step(1, 1, 0);
        check("confirm_entry", int'(state), 2);
        step(1, 1, 1);
        check("both_to_hunt", int'(state), 1);
        step(1, 1, 0); step(1, 1, 0);
        check("comma_cleared", int'(state), 2);
        step(1, 1, 0);
        step(0, 0, 0);
        check("relock_valid", int'(rxValid), 1);

        #3 rst = 1'b0;
        #1;
        check("async_rxValid", int'(rxValid), 0);
        check("async_state", int'(state), 0);
        check("async_syncLost", int'(syncLost), 0);
        @(negedge clk); #1;
        rst = 1'b1;
        step(0, 0, 0);
        check("no_lost_after_rst", int'(syncLost), 0);

        slips = 0;
        for (int n = 0; n < 10; n++) begin
            step(1, 0, 0);
            slips += int'(bitSlip);
        end
        check("slip_10", slips, 1);
        for (int n = 0; n < 10; n++) begin
            step(1, 0, 0);
            slips += int'(bitSlip);
        end
        check("slip_20", slips, 2);

        for (int blk = 0; blk < 6; blk++) begin
            inv_pct = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 10 : 25);
            k_pct   = (blk % 2 == 0) ? 50 : 5;
            for (int c = 0; c < 500; c++) begin
                rst     = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
                enb     = ($urandom_range(0, 99) < 98) ? 1'b1 : 1'b0;
                dataSIn = 2'($urandom_range(0, 3));
                step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < k_pct) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < inv_pct) ? 1'b1 : 1'b0);
            end
        end
        rst = 1'b1;
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
